pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: tracks outstanding instruction/data memory
// responses, derives buffer load/select/squash controls and keeps perf counters.
package pipeline_ctrl_pkg;
    typedef enum logic [2:0] {
        use_old   = 3'd0,
        use_ifid  = 3'd1,
        use_idex  = 3'd2,
        use_exmem = 3'd3,
        use_memwb = 3'd4
    } buffer_sel_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_I  = 2'd1,
        WAIT_D  = 2'd2,
        WAIT_ID = 2'd3
    } state_t;
endpackage

module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_resp,
    input  logic        dmem_resp,
    input  logic        mem_access,
    input  logic        mispredict,
    input  logic        load_use,
    output logic        imem_read,
    output logic        dmem_req,
    output logic        pc_load,
    output logic        load_ifid,
    output logic        load_idex,
    output logic        load_exmem,
    output logic        load_memwb,
    output buffer_sel_t sel_ifid,
    output buffer_sel_t sel_idex,
    output buffer_sel_t sel_exmem,
    output buffer_sel_t sel_memwb,
    output logic        squash_ifid,
    output logic        squash_idex,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    state_t      state;
    state_t      state_next;
    logic        i_done;
    logic        d_done;
    logic        i_ok;
    logic        d_ok;
    logic        advance;
    logic        stall_inc;
    logic        flush_inc;
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // A response in the current cycle counts immediately, so advance costs no extra cycle.
    assign i_ok    = i_done | imem_resp;
    assign d_ok    = !mem_access | d_done | dmem_resp;
    assign advance = i_ok & d_ok;

    always_comb begin
        state_next = RUN;
        case ({i_ok, d_ok})
            2'b11:   state_next = RUN;
            2'b01:   state_next = WAIT_I;
            2'b10:   state_next = WAIT_D;
            default: state_next = WAIT_ID;
        endcase
    end

    // NOTE: every output gets a default before any branch so no path leaves it
    // unassigned; an unassigned path in always_comb would infer a latch.
    always_comb begin
        imem_read   = 1'b0;
        dmem_req    = 1'b0;
        pc_load     = 1'b0;
        load_ifid   = 1'b0;
        load_idex   = 1'b0;
        load_exmem  = 1'b0;
        load_memwb  = 1'b0;
        squash_ifid = 1'b0;
        squash_idex = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        // Outputs are gated by rst so they reach reset values without a clock edge.
        if (rst) begin
            imem_read = !i_done;
            dmem_req  = mem_access & !d_done;
            if (!advance) begin
                stall_inc = 1'b1;
            end else if (mispredict) begin
                pc_load     = 1'b1;
                load_ifid   = 1'b1;
                load_idex   = 1'b1;
                load_exmem  = 1'b1;
                load_memwb  = 1'b1;
                squash_ifid = 1'b1;
                squash_idex = 1'b1;
                flush_inc   = 1'b1;
            end else if (load_use) begin
                load_idex   = 1'b1;
                squash_idex = 1'b1;
                load_exmem  = 1'b1;
                load_memwb  = 1'b1;
                stall_inc   = 1'b1;
            end else begin
                pc_load    = 1'b1;
                load_ifid  = 1'b1;
                load_idex  = 1'b1;
                load_exmem = 1'b1;
                load_memwb = 1'b1;
            end
        end
    end

    assign sel_ifid  = load_ifid  ? use_ifid  : use_old;
    assign sel_idex  = load_idex  ? use_idex  : use_old;
    assign sel_exmem = load_exmem ? use_exmem : use_old;
    assign sel_memwb = load_memwb ? use_memwb : use_old;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            i_done <= 1'b0;
            d_done <= 1'b0;
        end else begin
            state <= state_next;
            if (advance) begin
                i_done <= 1'b0;
                d_done <= 1'b0;
            end else begin
                i_done <= i_done | imem_resp;
                d_done <= d_done | (mem_access & dmem_resp);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
            if (flush_inc && flush_q != 32'hFFFF_FFFF) flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule
